// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the ITCM SRAM controller and its 1RW macro model.
package sram_ctrl_pkg;

   localparam int AW_DEF      = 32;
   localparam int DW_DEF      = 32;
   localparam int DEPTH_W_DEF = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RSP  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/sram_1rw.sv
// Behavioural 1RW synchronous SRAM: byte-masked write, read data valid the cycle after cs&!we.
// dout holds its value across writes and idle cycles; no reset, like a real macro.
module sram_1rw
   import sram_ctrl_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF
) (
   input  logic               clk,
   input  logic               cs,
   input  logic               we,
   input  logic [DEPTH_W-1:0] addr,
   input  logic [DW-1:0]      wdata,
   input  logic [DW/8-1:0]    wem,
   output logic [DW-1:0]      dout
);

   logic [DW-1:0] mem [0:(1<<DEPTH_W)-1];

   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) begin
            for (int b = 0; b < DW/8; b++) begin
               if (wem[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            dout <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: one rsp per accepted cmd, 1 cycle after accept, back-to-back capable.
// A response stalled by rsp_rdy=0 is parked in hold_q (HOLD) so the macro output may move on.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic [AW-1:0]      cmd_addr,
   input  logic               cmd_read,
   input  logic [DW-1:0]      cmd_wdata,
   input  logic [DW/8-1:0]    cmd_wmask,
   output logic               rsp_vld,
   input  logic               rsp_rdy,
   output logic               rsp_err,
   output logic [DW-1:0]      rsp_rdata,
   output logic               ram_cs,
   output logic               ram_we,
   output logic [DEPTH_W-1:0] ram_addr,
   output logic [DW-1:0]      ram_wdata,
   output logic [DW/8-1:0]    ram_wem,
   input  logic [DW-1:0]      ram_dout
);

   state_t        state;
   logic          is_read_q;
   logic          err_q;
   logic [DW-1:0] hold_q;
   logic [DW-1:0] rdata_c;
   logic          err_c;
   logic          accept;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^cmd_addr[1:0];

   assign err_c   = |cmd_addr[AW-1:DEPTH_W+2];
   assign cmd_rdy = (state == ST_IDLE) | ((state == ST_RSP) & rsp_rdy);
   // Gating with rst keeps the macro quiet for the whole reset window, not just after the edge.
   assign accept  = cmd_vld & cmd_rdy & ~rst;

   assign ram_cs    = accept & ~err_c;
   assign ram_we    = ~cmd_read;
   assign ram_wem   = cmd_read ? '0 : cmd_wmask;
   assign ram_addr  = cmd_addr[DEPTH_W+1:2];
   assign ram_wdata = cmd_wdata;

   always_comb begin
      rdata_c = '0;
      case (state)
         ST_RSP:  if (is_read_q && !err_q) rdata_c = ram_dout;
         ST_HOLD: rdata_c = hold_q;
         default: rdata_c = '0;
      endcase
   end

   assign rsp_vld   = (state != ST_IDLE);
   assign rsp_err   = rsp_vld & err_q;
   assign rsp_rdata = rdata_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         is_read_q <= 1'b0;
         err_q     <= 1'b0;
         hold_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state     <= ST_RSP;
                  is_read_q <= cmd_read;
                  err_q     <= err_c;
               end
            end
            ST_RSP: begin
               if (rsp_rdy) begin
                  if (accept) begin
                     is_read_q <= cmd_read;
                     err_q     <= err_c;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  hold_q <= rdata_c;
                  state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (rsp_rdy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl + sram_1rw: directed literal cases, then randomized traffic against a
// transaction-level model (word memory + queue of owed responses) checked every cycle.
module tb_sram_ctrl;

   logic        clk;
   logic        rst;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [31:0] cmd_addr;
   logic        cmd_read;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        ram_cs;
   logic        ram_we;
   logic [13:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_wem;
   logic [31:0] ram_dout;

   int vectors = 0;
   int miscompares = 0;

   sram_ctrl u_dut (
      .clk(clk), .rst(rst),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_read(cmd_read),
      .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wem(ram_wem), .ram_dout(ram_dout)
   );

   sram_1rw u_ram (
      .clk(clk), .cs(ram_cs), .we(ram_we), .addr(ram_addr),
      .wdata(ram_wdata), .wem(ram_wem), .dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: memory contents and the response each accepted cmd is owed.
   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic [31:0] mdl_mem [int];
   rsp_t        exp_q [$];
   bit          stalled = 0;

   always @(negedge clk) begin : cmp
      logic exp_rdy, acc, aerr;
      int   idx;
      rsp_t r;
      if (rst) begin
         chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
         chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
         chk("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
         exp_q.delete();
         stalled = 0;
      end else begin
         // A response that has already been refused once blocks new commands until drained.
         exp_rdy = (exp_q.size() == 0) || (rsp_rdy && !stalled);
         chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, exp_rdy});
         chk("rsp_vld", {31'd0, rsp_vld}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) begin
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
            chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
         end
         aerr = (cmd_addr >> 16) != 0;
         acc  = cmd_vld && exp_rdy;
         chk("ram_cs", {31'd0, ram_cs}, {31'd0, acc && !aerr});
         if (cmd_vld) begin
            chk("ram_addr", {18'd0, ram_addr}, (cmd_addr >> 2) & 32'h3FFF);
            chk("ram_we", {31'd0, ram_we}, {31'd0, !cmd_read});
            chk("ram_wem", {28'd0, ram_wem}, cmd_read ? 32'd0 : {28'd0, cmd_wmask});
         end
         if (exp_q.size() != 0) begin
            if (rsp_rdy) begin
               void'(exp_q.pop_front());
               stalled = 0;
            end else begin
               stalled = 1;
            end
         end
         if (acc) begin
            idx     = int'((cmd_addr >> 2) & 32'h3FFF);
            r.err   = aerr;
            r.rdata = (cmd_read && !aerr) ? mdl_mem[idx] : 32'd0;
            if (!cmd_read && !aerr) begin
               for (int b = 0; b < 4; b++)
                  if (cmd_wmask[b]) mdl_mem[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
            end
            exp_q.push_back(r);
         end
      end
   end

   task automatic do_cmd(input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output logic [31:0] rdat, output logic e);
      int n;
      @(posedge clk); #1;
      cmd_vld = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m; rsp_rdy = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("accept_in_time", {31'd0, n < 50}, 32'd1);
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      @(negedge clk);
      chk("rsp_latency", {31'd0, rsp_vld}, 32'd1);
      rdat = rsp_rdata;
      e    = rsp_err;
   endtask

   logic [31:0] rd_v;
   logic        er_v;
   logic [31:0] t3 [3];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_vld = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wmask = '0; rsp_rdy = 1'b1;
      #2;
      chk("reset_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
      #20; rst = 1'b0;

      // Full-word write then read back.
      do_cmd(1'b0, 32'h100, 32'hDEADBEEF, 4'hF, rd_v, er_v);
      chk("t1_wr_rdata", rd_v, 32'd0);
      do_cmd(1'b1, 32'h100, 32'h0, 4'h0, rd_v, er_v);
      chk("t1_rdata", rd_v, 32'hDEADBEEF);
      chk("t1_err", {31'd0, er_v}, 32'd0);

      // Partial byte mask over all-ones.
      do_cmd(1'b0, 32'h104, 32'hFFFFFFFF, 4'hF, rd_v, er_v);
      do_cmd(1'b0, 32'h104, 32'h11223344, 4'b0101, rd_v, er_v);
      do_cmd(1'b1, 32'h104, 32'h0, 4'h0, rd_v, er_v);
      chk("t2_rdata", rd_v, 32'hFF22FF44);

      // Back-to-back reads, one response per cycle.
      t3[0] = 32'hA0A0_0000; t3[1] = 32'hA4A4_0004; t3[2] = 32'hA8A8_0008;
      for (int i = 0; i < 3; i++) do_cmd(1'b0, 32'(4 * i), t3[i], 4'hF, rd_v, er_v);
      @(posedge clk); #1;
      cmd_vld = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0; rsp_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            cmd_addr = 32'(4 * i);
         end
         @(negedge clk);
         chk("t3_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
         if (i > 0) begin
            chk("t3_rsp_vld", {31'd0, rsp_vld}, 32'd1);
            chk("t3_rdata", rsp_rdata, t3[i-1]);
         end
      end
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      @(negedge clk);
      chk("t3_rsp_vld_last", {31'd0, rsp_vld}, 32'd1);
      chk("t3_rdata_last", rsp_rdata, t3[2]);

      // Stalled read with a write waiting behind it; mask-0 write must not change memory.
      @(posedge clk); #1;
      cmd_vld = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h100; rsp_rdy = 1'b0;
      @(negedge clk);
      chk("t4_accept", {31'd0, cmd_rdy}, 32'd1);
      @(posedge clk); #1;
      cmd_read = 1'b0; cmd_wdata = 32'h0; cmd_wmask = 4'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
         chk("t4_rsp_vld", {31'd0, rsp_vld}, 32'd1);
         chk("t4_rdata", rsp_rdata, 32'hDEADBEEF);
      end
      @(posedge clk); #1;
      rsp_rdy = 1'b1;
      @(negedge clk);
      chk("t4_hold_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("t4_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_idle_rdy", {31'd0, cmd_rdy}, 32'd1);
      chk("t4_wr_cs", {31'd0, ram_cs}, 32'd1);
      chk("t4_wr_wem", {28'd0, ram_wem}, 32'd0);
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      @(negedge clk);
      chk("t4_wr_rsp", {31'd0, rsp_vld}, 32'd1);

      // Out-of-range address.
      @(posedge clk); #1;
      cmd_vld = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h1 << 16;
      @(negedge clk);
      chk("t5_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
      chk("t5_ram_cs", {31'd0, ram_cs}, 32'd0);
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      @(negedge clk);
      chk("t5_rsp_vld", {31'd0, rsp_vld}, 32'd1);
      chk("t5_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("t5_rdata", rsp_rdata, 32'd0);

      // Reset while a response is held.
      @(posedge clk); #1;
      cmd_vld = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h100; rsp_rdy = 1'b0;
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_held", {31'd0, rsp_vld}, 32'd1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("t6_rsp_vld", {31'd0, rsp_vld}, 32'd0);
      chk("t6_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
      @(posedge clk); #3;
      rst = 1'b0; rsp_rdy = 1'b1;
      do_cmd(1'b1, 32'h100, 32'h0, 4'h0, rd_v, er_v);
      chk("t6_rdata", rd_v, 32'hDEADBEEF);
      chk("t6_err", {31'd0, er_v}, 32'd0);

      // Seed the random window with known contents.
      for (int i = 0; i < 64; i++) do_cmd(1'b0, 32'(4 * i), $urandom, 4'hF, rd_v, er_v);

      repeat (3000) begin
         @(posedge clk); #1;
         cmd_vld   = ($urandom % 4) != 0;
         cmd_read  = $urandom % 2;
         cmd_addr  = {16'h0, 8'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
         if ($urandom % 8 == 0) cmd_addr = $urandom | 32'h0001_0000;
         cmd_wdata = $urandom;
         cmd_wmask = 4'($urandom);
         rsp_rdy   = ($urandom % 4) != 0;
      end
      @(posedge clk); #1;
      cmd_vld = 1'b0; rsp_rdy = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("drained", {31'd0, rsp_vld}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
